zclock_gen: RTL and testbench
=============================

Name: zclock_gen

Overview:
Parametrised Z80 clock generator. Derives zclk_out and the zpos/zneg phase strobes from the system clock, with a selectable divider per turbo code. Mode switches are deferred to a refresh-safe zclk edge. Clock advance is held off by level stalls (cpu, ide) and by counted wait-state stalls (DOS entry/exit, external IO at fast modes). Sits between the turbo/port decode logic and the CPU core, replacing the fixed 3-mode clocking unit.

Parameters:
TURBO_W, 2, width of the turbo select code
HP_LOG_MAX, 2, log2 of the slowest half-period in clk cycles; code t gives half-period HP(t) = 2^(HP_LOG_MAX - min(t, HP_LOG_MAX))
WAIT_W, 4, width of the wait-state counter
DOS_WAIT, 4, clk cycles of stall per dos_trig
IO_WAIT, 8, clk cycles of stall per io_trig
IO_SLOW_HP, 2, io_trig stalls only when the current HP < IO_SLOW_HP

Ports:
clk  in  1  system clock (28 MHz nominal)
rst_n  in  1  asynchronous active-low reset
turbo  in  TURBO_W  requested speed code; 0 = slowest
rfsh_n  in  1  Z80 refresh, active low, synchronous to clk
cpu_stall  in  1  level stall (memory arbitration)
ide_stall  in  1  level stall (IDE access)
dos_trig  in  1  one-cycle pulse: DOS map change
io_trig  in  1  one-cycle pulse: external-port IORQ start
zclk_out  out  1  generated Z80 clock (registered)
zpos  out  1  one-clk strobe coincident with the zclk_out 1->0 transition
zneg  out  1  one-clk strobe coincident with the zclk_out 0->1 transition
turbo_cur  out  TURBO_W  turbo code currently in effect
stall_active  out  1  stall is suppressing zclk advance this cycle

Behaviour:
- Reset (async, rst_n=0): zclk_out=0, zpos=0, zneg=0, turbo_cur=0, half-period counter=0, wait counter=0, pending-switch flag=0. The first posedge after release counts normally.
- stall = cpu_stall | ide_stall | dos_trig | io_stall_now | (wait_cnt != 0). stall_active is the combinational stall. io_stall_now = io_trig & (HP(turbo_cur) < IO_SLOW_HP).
- Wait counter:
  - On dos_trig and/or io_stall_now, load max(wait_cnt, each applicable length). DOS_WAIT and IO_WAIT are treated as lengths. The loaded value counts the trigger cycle itself.
  - Otherwise decrement while nonzero. Saturating; never wraps below 0.
  - A trigger while already counting never shortens the stall.
- Half-period counter hp_cnt, width HP_LOG_MAX+1:
  - Stall: hp_cnt, zclk_out and turbo_cur hold; zpos=zneg=0.
  - Not stalled, hp_cnt != HP-1: hp_cnt++.
  - Not stalled, hp_cnt == HP-1: hp_cnt<=0 and zclk_out toggles. zpos<=1 if zclk_out was 1; zneg<=1 if zclk_out was 0.
  - zpos and zneg are never both 1 and are always 1 clk wide.
- Resulting zclk periods for the default parameters: turbo 0 = 8 clk (3.5 MHz), 1 = 4 clk (7 MHz), 2 or 3 = 2 clk (14 MHz). Duty cycle is 50% except when stretched by stalls.
- Mode switch:
  - pending is set when turbo != turbo_cur.
  - The switch applies only on a cycle that produces zneg while rfsh_n=0. On that cycle turbo_cur<=turbo and hp_cnt<=0, so the new HP governs the following low... high half.
  - If turbo returns to turbo_cur before application, pending clears and nothing changes.
  - No glitch: no half-period is ever shorter than min(old HP, new HP).
- Simultaneous stall and terminal count: the stall wins and the toggle is deferred.
- rst_n asserted mid-half-period drives the outputs to reset values immediately; no strobe is emitted.

Test Plan:
- Reset, turbo=0, no stalls, 40 clk -> zclk_out period 8 clk (4 high, 4 low). zneg on each 0->1, zpos on each 1->0. turbo_cur=0.
- turbo=2 with rfsh_n=1 for 50 clk, then rfsh_n=0 -> period stays 8 until the first zneg with rfsh_n=0. Then 2-clk period, turbo_cur=2, no half-period <1 clk.
- turbo_cur=2, io_trig pulse -> stall_active high for exactly 8 clk, zclk_out frozen, no strobes. Same pulse at turbo_cur=1 -> no stall.
- dos_trig at cycle 0, io_trig at cycle 2 (turbo_cur=2) -> wait counter reloaded to 8 at cycle 2. Stall covers cycles 0..9 (10 clk total).
- cpu_stall held 5 clk on the clk where hp_cnt==HP-1 -> toggle occurs on the first unstalled cycle after release. Half-period stretched by exactly 5.
- rst_n pulsed low mid-high-phase at turbo=1 -> zclk_out=0 and turbo_cur=0 at once. After release, an 8-clk period resumes.

Source files
------------

// File: rtl/zclock_gen.sv
// Z80 clock generator: divides clk into zclk_out with zpos/zneg strobes, one registered cycle after the deciding clk.
// Stalls (level or counted wait states) freeze the clock; turbo changes are applied only at a refresh-time rising edge.
module zclock_gen #(
    parameter int TURBO_W    = 2,
    parameter int HP_LOG_MAX = 2,
    parameter int WAIT_W     = 4,
    parameter int DOS_WAIT   = 4,
    parameter int IO_WAIT    = 8,
    parameter int IO_SLOW_HP = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [TURBO_W-1:0] turbo,
    input  logic               rfsh_n,
    input  logic               cpu_stall,
    input  logic               ide_stall,
    input  logic               dos_trig,
    input  logic               io_trig,
    output logic               zclk_out,
    output logic               zpos,
    output logic               zneg,
    output logic [TURBO_W-1:0] turbo_cur,
    output logic               stall_active
);

    localparam int HPW = HP_LOG_MAX + 1;
    localparam logic [WAIT_W-1:0] DOS_LEN = WAIT_W'(DOS_WAIT);
    localparam logic [WAIT_W-1:0] IO_LEN  = WAIT_W'(IO_WAIT);

    logic               r_zclk;
    logic               r_zpos;
    logic               r_zneg;
    logic               r_pending;
    logic [TURBO_W-1:0] r_turbo_cur;
    logic [HPW-1:0]     r_hp_cnt;
    logic [WAIT_W-1:0]  r_wait_cnt;

    logic [HPW-1:0]     w_hp;
    logic [HPW-1:0]     w_hp_last;
    logic               w_io_stall_now;
    logic               w_stall;
    logic               w_toggle;
    logic               w_differ;
    logic               w_apply;
    logic [WAIT_W-1:0]  w_wait_max;
    logic [WAIT_W-1:0]  w_wait_nxt;

    // Half-period in clk cycles for a turbo code; codes beyond HP_LOG_MAX saturate at 1.
    function automatic logic [HPW-1:0] hp_of(input logic [TURBO_W-1:0] t);
        int sh;
        sh = (int'(t) >= HP_LOG_MAX) ? 0 : HP_LOG_MAX - int'(t);
        return HPW'(1) << sh;
    endfunction

    always_comb begin
        w_hp           = hp_of(r_turbo_cur);
        w_hp_last      = w_hp - HPW'(1);
        w_io_stall_now = io_trig && (int'(w_hp) < IO_SLOW_HP);
        w_stall        = cpu_stall | ide_stall | dos_trig | w_io_stall_now | (r_wait_cnt != '0);

        // The counter holds remaining stall cycles including the current one, so the
        // trigger cycle consumes one unit of the loaded length.
        w_wait_max = r_wait_cnt;
        if (dos_trig && (DOS_LEN > w_wait_max)) begin
            w_wait_max = DOS_LEN;
        end
        if (w_io_stall_now && (IO_LEN > w_wait_max)) begin
            w_wait_max = IO_LEN;
        end
        w_wait_nxt = (w_wait_max != '0) ? (w_wait_max - WAIT_W'(1)) : '0;

        w_toggle = !w_stall && (r_hp_cnt >= w_hp_last);
        w_differ = (turbo != r_turbo_cur);
        // Switching only on a refresh-time rising edge restarts a full new half-period,
        // so no half can be shorter than the smaller of the two periods.
        w_apply  = w_toggle && !r_zclk && !rfsh_n && r_pending && w_differ;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zclk      <= 1'b0;
            r_zpos      <= 1'b0;
            r_zneg      <= 1'b0;
            r_pending   <= 1'b0;
            r_turbo_cur <= '0;
            r_hp_cnt    <= '0;
            r_wait_cnt  <= '0;
        end else begin
            r_wait_cnt <= w_wait_nxt;
            r_pending  <= w_differ && !w_apply;
            r_zpos     <= w_toggle && r_zclk;
            r_zneg     <= w_toggle && !r_zclk;
            if (w_toggle) begin
                r_zclk   <= !r_zclk;
                r_hp_cnt <= '0;
                if (w_apply) begin
                    r_turbo_cur <= turbo;
                end
            end else if (!w_stall) begin
                r_hp_cnt <= r_hp_cnt + HPW'(1);
            end
        end
    end

    assign zclk_out     = r_zclk;
    assign zpos         = r_zpos;
    assign zneg         = r_zneg;
    assign turbo_cur    = r_turbo_cur;
    assign stall_active = w_stall;

    a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n) !(r_zpos && r_zneg));
    a_stall_quiet: assert property (@(posedge clk) disable iff (!rst_n) w_stall |=> !(r_zpos || r_zneg));

endmodule

// File: tb/tb_zclock_gen.sv
// Bench for zclock_gen: directed scenarios plus random traffic against a cycle-level behavioural model.
module tb_zclock_gen;

    localparam int HP_LOG_MAX = 2;
    localparam int DOS_WAIT   = 4;
    localparam int IO_WAIT    = 8;
    localparam int IO_SLOW_HP = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] turbo;
    logic       rfsh_n, cpu_stall, ide_stall, dos_trig, io_trig;
    logic       zclk_out, zpos, zneg, stall_active;
    logic [1:0] turbo_cur;

    int errs = 0;
    int checks = 0;

    // behavioural model: elapsed unstalled cycles in the current half, absolute stall end time
    bit       m_zclk, exp_zpos, exp_zneg, m_pend, exp_stall, obs_stall;
    bit [1:0] m_tcur;
    int       m_el, m_cyc, m_end;

    zclock_gen #(
        .TURBO_W(2), .HP_LOG_MAX(HP_LOG_MAX), .WAIT_W(4),
        .DOS_WAIT(DOS_WAIT), .IO_WAIT(IO_WAIT), .IO_SLOW_HP(IO_SLOW_HP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .turbo(turbo), .rfsh_n(rfsh_n),
        .cpu_stall(cpu_stall), .ide_stall(ide_stall), .dos_trig(dos_trig), .io_trig(io_trig),
        .zclk_out(zclk_out), .zpos(zpos), .zneg(zneg), .turbo_cur(turbo_cur),
        .stall_active(stall_active)
    );

    always #5 clk = ~clk;

    function automatic int hp_of(int t);
        int lim;
        lim = (t > HP_LOG_MAX) ? HP_LOG_MAX : t;
        return 2 ** (HP_LOG_MAX - lim);
    endfunction

    task automatic model_reset();
        m_zclk = 0; exp_zpos = 0; exp_zneg = 0; m_pend = 0;
        m_tcur = 0; m_el = 0; m_end = m_cyc;
    endtask

    // Advance one clk: sample the combinational stall, step the model, then pass the edge.
    task automatic tick();
        int hp;
        bit io_now, applied;
        bit [1:0] told;
        #1;
        hp = hp_of(int'(m_tcur));
        io_now = io_trig && (hp < IO_SLOW_HP);
        if (dos_trig && m_end < m_cyc + DOS_WAIT) m_end = m_cyc + DOS_WAIT;
        if (io_now && m_end < m_cyc + IO_WAIT) m_end = m_cyc + IO_WAIT;
        exp_stall = cpu_stall || ide_stall || (m_cyc < m_end);
        obs_stall = stall_active;
        told = m_tcur; applied = 0; exp_zpos = 0; exp_zneg = 0;
        if (!exp_stall) begin
            m_el++;
            if (m_el == hp) begin
                m_el = 0;
                exp_zpos = m_zclk;
                exp_zneg = !m_zclk;
                if (!m_zclk && !rfsh_n && m_pend && turbo != m_tcur) begin
                    m_tcur = turbo;
                    applied = 1;
                end
                m_zclk = !m_zclk;
            end
        end
        m_pend = (turbo != told) && !applied;
        m_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic goto_turbo(input bit [1:0] t);
        int n;
        turbo = t; rfsh_n = 0; n = 0;
        while (m_tcur != t && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (turbo_cur !== t) begin
            errs++;
            $display("FAIL goto_turbo got=%0d want=%0d after %0d clk", turbo_cur, t, n);
        end
        rfsh_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; turbo = 0; rfsh_n = 1; cpu_stall = 0; ide_stall = 0; dos_trig = 0; io_trig = 0;
        m_cyc = 0;
        model_reset();
        #2;
        checks++; if (zclk_out !== 1'b0) begin errs++; $display("FAIL reset_zclk got=%b want=0", zclk_out); end
        checks++; if (zpos !== 1'b0) begin errs++; $display("FAIL reset_zpos got=%b want=0", zpos); end
        checks++; if (zneg !== 1'b0) begin errs++; $display("FAIL reset_zneg got=%b want=0", zneg); end
        checks++; if (turbo_cur !== 2'd0) begin errs++; $display("FAIL reset_turbo got=%0d want=0", turbo_cur); end
        checks++; if (stall_active !== 1'b0) begin errs++; $display("FAIL reset_stall got=%b want=0", stall_active); end
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic test_slow_period();
        int nneg, npos, nhigh;
        nneg = 0; npos = 0; nhigh = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++; if (zclk_out !== m_zclk) begin errs++; $display("FAIL slow_zclk cyc=%0d got=%b want=%b", m_cyc, zclk_out, m_zclk); end
            checks++; if (zpos !== exp_zpos) begin errs++; $display("FAIL slow_zpos cyc=%0d got=%b want=%b", m_cyc, zpos, exp_zpos); end
            checks++; if (zneg !== exp_zneg) begin errs++; $display("FAIL slow_zneg cyc=%0d got=%b want=%b", m_cyc, zneg, exp_zneg); end
            nneg += int'(zneg); npos += int'(zpos); nhigh += int'(zclk_out);
        end
        checks++; if (nneg != 5) begin errs++; $display("FAIL slow_zneg_count got=%0d want=5", nneg); end
        checks++; if (npos != 5) begin errs++; $display("FAIL slow_zpos_count got=%0d want=5", npos); end
        checks++; if (nhigh != 20) begin errs++; $display("FAIL slow_high_cycles got=%0d want=20", nhigh); end
        checks++; if (turbo_cur !== 2'd0) begin errs++; $display("FAIL slow_turbo got=%0d want=0", turbo_cur); end
    endtask

    task automatic test_mode_switch();
        int n, ntog;
        bit prev;
        turbo = 2; rfsh_n = 1;
        for (int i = 0; i < 50; i++) begin
            tick();
            checks++; if (zclk_out !== m_zclk) begin errs++; $display("FAIL sw_hold_zclk cyc=%0d got=%b want=%b", m_cyc, zclk_out, m_zclk); end
            checks++; if (turbo_cur !== m_tcur) begin errs++; $display("FAIL sw_hold_turbo cyc=%0d got=%0d want=%0d", m_cyc, turbo_cur, m_tcur); end
        end
        checks++; if (turbo_cur !== 2'd0) begin errs++; $display("FAIL sw_no_refresh got=%0d want=0", turbo_cur); end
        rfsh_n = 0; n = 0;
        while (m_tcur != 2 && n < 20) begin
            tick();
            checks++; if (zclk_out !== m_zclk) begin errs++; $display("FAIL sw_wait_zclk cyc=%0d got=%b want=%b", m_cyc, zclk_out, m_zclk); end
            n++;
        end
        checks++; if (turbo_cur !== 2'd2 || zclk_out !== 1'b1 || zneg !== 1'b1) begin
            errs++; $display("FAIL sw_apply turbo=%0d zclk=%b zneg=%b want 2/1/1", turbo_cur, zclk_out, zneg);
        end
        ntog = 0; prev = zclk_out;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (zclk_out !== m_zclk) begin errs++; $display("FAIL sw_fast_zclk cyc=%0d got=%b want=%b", m_cyc, zclk_out, m_zclk); end
            ntog += int'(zclk_out != prev); prev = zclk_out;
        end
        checks++; if (ntog != 10) begin errs++; $display("FAIL sw_fast_toggles got=%0d want=10", ntog); end
        rfsh_n = 1;
    endtask

    task automatic test_io_stall();
        int nst, nstr;
        bit z0;
        z0 = zclk_out; nst = 0; nstr = 0;
        io_trig = 1;
        tick();
        io_trig = 0;
        nst += int'(obs_stall);
        for (int i = 1; i < 12; i++) begin
            tick();
            nst += int'(obs_stall);
            if (i < 8) nstr += int'(zpos) + int'(zneg);
            if (i == 7) begin
                checks++; if (zclk_out !== z0) begin errs++; $display("FAIL io_frozen got=%b want=%b", zclk_out, z0); end
            end
        end
        checks++; if (nst != 8) begin errs++; $display("FAIL io_stall_len got=%0d want=8", nst); end
        checks++; if (nstr != 0) begin errs++; $display("FAIL io_strobes got=%0d want=0", nstr); end
        goto_turbo(1);
        io_trig = 1;
        tick();
        io_trig = 0;
        checks++; if (obs_stall !== 1'b0) begin errs++; $display("FAIL io_no_stall_t1 got=%b want=0", obs_stall); end
    endtask

    task automatic test_dos_io();
        int nst;
        goto_turbo(2);
        nst = 0;
        for (int i = 0; i < 12; i++) begin
            dos_trig = (i == 0);
            io_trig = (i == 2);
            tick();
            nst += int'(obs_stall);
            checks++; if (obs_stall !== (i < 10)) begin errs++; $display("FAIL dosio_stall cyc=%0d got=%b want=%b", i, obs_stall, (i < 10)); end
        end
        dos_trig = 0; io_trig = 0;
        checks++; if (nst != 10) begin errs++; $display("FAIL dosio_len got=%0d want=10", nst); end
    endtask

    task automatic test_cpu_stall();
        int n;
        bit z0;
        goto_turbo(0);
        n = 0;
        while (m_el != 3 && n < 20) begin
            tick();
            n++;
        end
        z0 = zclk_out;
        cpu_stall = 1;
        for (int i = 0; i < 5; i++) tick();
        cpu_stall = 0;
        checks++; if (zclk_out !== z0) begin errs++; $display("FAIL cpu_held got=%b want=%b", zclk_out, z0); end
        tick();
        checks++; if (zclk_out !== !z0) begin errs++; $display("FAIL cpu_release_toggle got=%b want=%b", zclk_out, !z0); end
        checks++; if ((z0 ? zpos : zneg) !== 1'b1) begin errs++; $display("FAIL cpu_release_strobe zpos=%b zneg=%b", zpos, zneg); end
    endtask

    task automatic test_reset_mid();
        int n, nrise;
        goto_turbo(1);
        n = 0;
        while (!(m_zclk && m_el == 0) && n < 20) begin
            tick();
            n++;
        end
        tick();
        checks++; if (zclk_out !== 1'b1) begin errs++; $display("FAIL mid_pre_high got=%b want=1", zclk_out); end
        rst_n = 0; turbo = 0; rfsh_n = 1;
        #1;
        checks++; if (zclk_out !== 1'b0) begin errs++; $display("FAIL mid_rst_zclk got=%b want=0", zclk_out); end
        checks++; if (turbo_cur !== 2'd0) begin errs++; $display("FAIL mid_rst_turbo got=%0d want=0", turbo_cur); end
        checks++; if (zpos !== 1'b0 || zneg !== 1'b0) begin errs++; $display("FAIL mid_rst_strobe zpos=%b zneg=%b want 0/0", zpos, zneg); end
        rst_n = 1;
        model_reset();
        nrise = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            checks++; if (zclk_out !== m_zclk) begin errs++; $display("FAIL mid_after_zclk cyc=%0d got=%b want=%b", m_cyc, zclk_out, m_zclk); end
            nrise += int'(zneg);
        end
        checks++; if (nrise != 3) begin errs++; $display("FAIL mid_after_rises got=%0d want=3", nrise); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) turbo = 2'($urandom_range(0, 3));
            rfsh_n    = ($urandom_range(0, 3) != 0);
            cpu_stall = ($urandom_range(0, 15) == 0);
            ide_stall = ($urandom_range(0, 15) == 0);
            dos_trig  = ($urandom_range(0, 49) == 0);
            io_trig   = ($urandom_range(0, 29) == 0);
            tick();
            checks++; if (obs_stall !== exp_stall) begin errs++; $display("FAIL rnd_stall cyc=%0d got=%b want=%b", m_cyc, obs_stall, exp_stall); end
            checks++; if (zclk_out !== m_zclk) begin errs++; $display("FAIL rnd_zclk cyc=%0d got=%b want=%b", m_cyc, zclk_out, m_zclk); end
            checks++; if (zpos !== exp_zpos) begin errs++; $display("FAIL rnd_zpos cyc=%0d got=%b want=%b", m_cyc, zpos, exp_zpos); end
            checks++; if (zneg !== exp_zneg) begin errs++; $display("FAIL rnd_zneg cyc=%0d got=%b want=%b", m_cyc, zneg, exp_zneg); end
            checks++; if (turbo_cur !== m_tcur) begin errs++; $display("FAIL rnd_turbo cyc=%0d got=%0d want=%0d", m_cyc, turbo_cur, m_tcur); end
        end
        cpu_stall = 0; ide_stall = 0; dos_trig = 0; io_trig = 0; rfsh_n = 1;
    endtask

    initial begin
        test_reset();
        test_slow_period();
        test_mode_switch();
        test_io_stall();
        test_dos_io();
        test_cpu_stall();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
